simproc_uart_rx: RTL and testbench

Parametrised UART receiver with an output FIFO, the next-generation receive path for the simproc system. It oversamples a serial line using a runtime-programmable clocks-per-bit divisor, supports configurable data width and FIFO depth, detects framing, overrun and (optionally) parity errors, and presents received words on a valid/ready interface to the processor core.

---
 rtl/simproc_uart_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_simproc_uart_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/simproc_uart_rx.sv
// Oversampling UART receiver with a valid/ready receive FIFO and sticky error flags.
// Define SIMPROC_UART_PARITY_EN to add a parity bit between the data and stop bits.
module simproc_uart_rx #(
    parameter int CLK_BITS   = 10,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CLK_BITS-1:0]             clk_per_bit,
    input  logic                            uart_rx,
    input  logic                            parity_odd,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            parity_err,
    input  logic                            clear_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SIMPROC_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic                 sync1_q, sync2_q, line_prev_q;
    logic                 rx_line;
    state_t               state_q, state_d;
    logic [CLK_BITS-1:0]  cnt_q, cnt_d;
    logic [CLK_BITS-1:0]  n_q, n_d;
    logic [CLK_BITS-1:0]  div_eff;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 sample;
    logic                 push_req, set_frame;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 pop, full, push_ok, push_ovf;
    logic                 frame_err_q, overrun_q;

    assign rx_line = sync2_q;
    assign sample  = (cnt_q == CLK_BITS'(1));
    assign div_eff = (clk_per_bit < CLK_BITS'(4)) ? CLK_BITS'(4) : clk_per_bit;

    // NOTE: every register below uses <= so all flops update together at the edge,
    // independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

`ifdef SIMPROC_UART_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic parity_bad;
    logic set_parity;
    logic parity_err_q;

    // Even parity: data plus parity bit has an even count of ones; odd sense flips it.
    assign parity_bad = ((^shreg_q) ^ par_bit_q) != parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= CLK_BITS'(4);
            bit_q   <= '0;
            shreg_q <= '0;
`ifdef SIMPROC_UART_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
`ifdef SIMPROC_UART_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        set_frame = 1'b0;
`ifdef SIMPROC_UART_PARITY_EN
        par_bit_d  = par_bit_q;
        set_parity = 1'b0;
`endif
        if (state_q != S_IDLE) cnt_d = cnt_q - CLK_BITS'(1);

        case (state_q)
            S_IDLE: begin
                if (line_prev_q && !rx_line) begin
                    n_d     = div_eff;
                    cnt_d   = div_eff >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rx_line) begin
                        cnt_d   = n_q;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d = {rx_line, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = n_q;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef SIMPROC_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef SIMPROC_UART_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = rx_line;
                    cnt_d     = n_q;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    state_d = S_IDLE;
                    if (!rx_line) set_frame = 1'b1;
`ifdef SIMPROC_UART_PARITY_EN
                    else if (parity_bad) set_parity = 1'b1;
`endif
                    else push_req = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = rx_valid && rx_ready;
    assign push_ok  = push_req && (!full || pop);
    assign push_ovf = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    end

    // NOTE: the storage array is deliberately not reset; entries are only visible
    // through rx_data while count_q says they were written, so reset cost is avoided.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            frame_err_q <= clear_err ? 1'b0 : (frame_err_q | set_frame);
            overrun_q   <= clear_err ? 1'b0 : (overrun_q | push_ovf);
        end
    end

`ifdef SIMPROC_UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= clear_err ? 1'b0 : (parity_err_q | set_parity);
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_simproc_uart_rx.sv
// Directed bench for simproc_uart_rx: single frames, glitch, framing, overrun,
// parity (when SIMPROC_UART_PARITY_EN is defined) and a mid-frame divisor change.
module tb_simproc_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  clk_per_bit;
    logic        uart_rx;
    logic        parity_odd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  fifo_count;
    logic        frame_err;
    logic        overrun;
    logic        parity_err;
    logic        clear_err;

    int n_checks = 0;
    int n_pass   = 0;

    simproc_uart_rx #(.CLK_BITS(10), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_per_bit(clk_per_bit),
        .uart_rx    (uart_rx),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clear_err  (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Drives one frame at n clocks per bit; inputs change on the falling clock edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic use_par, input logic par_bit, input int n);
        uart_rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (n) @(negedge clk);
        end
        if (use_par) begin
            uart_rx = par_bit;
            repeat (n) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (n) @(negedge clk);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] data, input int n);
`ifdef SIMPROC_UART_PARITY_EN
        send_frame(data, 1'b1, 1'b1, (^data) ^ parity_odd, n);
`else
        send_frame(data, 1'b1, 1'b0, 1'b0, n);
`endif
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        clk_per_bit = 10'd16;
        uart_rx     = 1'b1;
        parity_odd  = 1'b0;
        rx_ready    = 1'b0;
        clear_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word held in the FIFO
        send_good(8'hA5, 16);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        pop_one();
        check("a5_pop_count", 32'(fifo_count), 32'd0);
        check("a5_pop_data", 32'(rx_data), 32'd0);

        // One-cycle glitch on an idle line
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        // Framing error, then clear
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
`ifdef SIMPROC_UART_PARITY_EN
        check("frame_count_par", 32'(fifo_count), 32'd0);
`else
        check("frame_count", 32'(fifo_count), 32'd0);
        check("frame_err_set", 32'(frame_err), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("frame_err_clr", 32'(frame_err), 32'd0);
`endif
`ifdef SIMPROC_UART_PARITY_EN
        // Data 0x3C and parity slot 0 form a valid parity; stop slot low is then framing
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 16);
        check("frame_err_set", 32'(frame_err), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("frame_err_clr", 32'(frame_err), 32'd0);
`endif

        // Overrun: five words into a four-entry FIFO
        for (int w = 1; w <= 5; w++) send_good(8'(w), 16);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_frame", 32'(frame_err), 32'd0);
        rx_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("ovr_pop%0d_valid", w), 32'(rx_valid), 32'd1);
            check($sformatf("ovr_pop%0d_data", w), 32'(rx_data), 32'(w));
            @(negedge clk);
        end
        rx_ready = 1'b0;
        check("ovr_empty", 32'(rx_valid), 32'd0);
        check("ovr_empty_count", 32'(fifo_count), 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

`ifdef SIMPROC_UART_PARITY_EN
        // 0x07 has three ones: even parity requires parity bit 1
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 16);
        check("par_ok_count", 32'(fifo_count), 32'd1);
        check("par_ok_data", 32'(rx_data), 32'h07);
        check("par_ok_flag", 32'(parity_err), 32'd0);
        pop_one();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 16);
        check("par_bad_count", 32'(fifo_count), 32'd0);
        check("par_bad_flag", 32'(parity_err), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("par_clr", 32'(parity_err), 32'd0);
`else
        check("par_tied", 32'(parity_err), 32'd0);
`endif

        // Divisor change mid-frame takes effect on the next frame only
        fork
            send_good(8'h5A, 16);
            begin
                repeat (40) @(negedge clk);
                clk_per_bit = 10'd8;
            end
        join
        check("div_old_count", 32'(fifo_count), 32'd1);
        check("div_old_data", 32'(rx_data), 32'h5A);
        pop_one();
        send_good(8'hC3, 8);
        check("div_new_count", 32'(fifo_count), 32'd1);
        check("div_new_data", 32'(rx_data), 32'hC3);
        check("div_new_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
